demux_stream_ctrl: RTL and testbench

- Packet-level steering controller for the 1-to-2 demux datapath.
- Accepts one valid/ready input stream and latches each packet's destination on its first beat.
- Steers every beat of that packet to output 0 or 1 through a one-entry output register.
- Drops packets addressed to a disabled output and keeps per-output packet and drop counters.

---
 rtl/demux_stream_ctrl_pkg.sv | 19 +
 rtl/demux_out_slot.sv | 67 ++++++
 rtl/demux_stream_ctrl.sv | 143 ++++++++++++++
 tb/tb_demux_stream_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_ctrl_pkg.sv
// Shared definitions for the packet-steering demux controller:
// FSM state encodings, default widths and the destination one-hot decode.
package demux_stream_ctrl_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_CW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    // Maps a 1-bit destination onto the two per-output valid lines.
    function automatic logic [1:0] dst_onehot(input logic dst);
        return dst ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot shared by both demux outputs.
// Holds one beat, decodes its destination into a one-hot valid and reports when it can take a new beat.
module demux_out_slot
    import demux_stream_ctrl_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    input  logic          dst_i,
    input  logic [1:0]    out_ready_i,
    output logic          free_o,
    output logic [1:0]    done_o,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic [1:0]    out_valid_o
);

    logic          valid_q, valid_d;
    logic          dst_q,   dst_d;
    logic          last_q,  last_d;
    logic [DW-1:0] data_q,  data_d;
    logic          drain;

    // Only the ready of the output the slot points at can drain it.
    assign drain  = valid_q && out_ready_i[dst_q];
    assign free_o = !valid_q || out_ready_i[dst_q];

    always_comb begin
        valid_d = valid_q;
        dst_d   = dst_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            dst_d   = dst_i;
            last_d  = last_i;
            data_d  = data_i;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the payload registers are reset too, not just valid, so out_data and out_last read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dst_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q ? dst_onehot(dst_q) : 2'b00;
    assign done_o      = (drain && last_q) ? dst_onehot(dst_q) : 2'b00;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/demux_stream_ctrl.sv
// Packet-level steering controller for the 1-to-2 demux: latches each packet's destination on its
// first beat, routes or drops the whole packet, and counts delivered and dropped packets.
module demux_stream_ctrl
    import demux_stream_ctrl_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic          in_dest,
    output logic          in_ready,
    input  logic [1:0]    en,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [1:0]    out_valid,
    input  logic [1:0]    out_ready,
    output logic          sel,
    output logic          busy,
    output logic [CW-1:0] pkt_cnt0,
    output logic [CW-1:0] pkt_cnt1,
    output logic [CW-1:0] drop_cnt
);

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic [CW-1:0] drop_q, drop_d;

    logic       ready;
    logic       accept;
    logic       load;
    logic       load_dst;
    logic       drop_done;
    logic       slot_free;
    logic [1:0] done;

    demux_out_slot #(.DW(DW)) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .data_i      (in_data),
        .last_i      (in_last),
        .dst_i       (load_dst),
        .out_ready_i (out_ready),
        .free_o      (slot_free),
        .done_o      (done),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_valid_o (out_valid)
    );

    // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ready     = 1'b0;
        load      = 1'b0;
        load_dst  = sel_q;
        drop_done = 1'b0;

        case (state_q)
            ST_IDLE:  ready = en[in_dest] ? slot_free : 1'b1;
            ST_ROUTE: ready = slot_free;
            ST_DROP:  ready = 1'b1;
            default:  ready = 1'b0;
        endcase
        if (rst) begin
            ready = 1'b0;
        end
        accept = in_valid && ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (en[in_dest]) begin
                        load     = 1'b1;
                        load_dst = in_dest;
                        sel_d    = in_dest;
                        if (!in_last) begin
                            state_d = ST_ROUTE;
                        end
                    end else if (in_last) begin
                        drop_done = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_ROUTE: begin
                if (accept) begin
                    load = 1'b1;
                    if (in_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (accept && in_last) begin
                    drop_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Delivery and drop events are independent; each counter wraps naturally at 2^CW.
    always_comb begin
        cnt0_d = cnt0_q + CW'(done[0]);
        cnt1_d = cnt1_q + CW'(done[1]);
        drop_d = drop_q + CW'(drop_done);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            drop_q  <= drop_d;
        end
    end

    assign in_ready = ready;
    assign sel      = sel_q;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Directed self-checking bench for demux_stream_ctrl; a second instance with CW=2 shares the
// stimulus so counter wrap-around can be observed alongside the default-width counters.
module tb_demux_stream_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_dest;
    logic [1:0] en;
    logic [1:0] out_ready;

    logic       in_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_valid;
    logic       sel;
    logic       busy;
    logic [7:0] pkt_cnt0;
    logic [7:0] pkt_cnt1;
    logic [7:0] drop_cnt;

    logic       w_in_ready;
    logic [7:0] w_out_data;
    logic       w_out_last;
    logic [1:0] w_out_valid;
    logic       w_sel;
    logic       w_busy;
    logic [1:0] w_pkt_cnt0;
    logic [1:0] w_pkt_cnt1;
    logic [1:0] w_drop_cnt;

    int checks   = 0;
    int failures = 0;

    demux_stream_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .en        (en),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy),
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1),
        .drop_cnt  (drop_cnt)
    );

    demux_stream_ctrl #(.DW(8), .CW(2)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_dest   (in_dest),
        .in_ready  (w_in_ready),
        .en        (en),
        .out_data  (w_out_data),
        .out_last  (w_out_last),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .sel       (w_sel),
        .busy      (w_busy),
        .pkt_cnt0  (w_pkt_cnt0),
        .pkt_cnt1  (w_pkt_cnt1),
        .drop_cnt  (w_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watches the producer hold rule and the one-hot property of out_valid on every edge.
    initial begin
        logic       stall;
        logic [7:0] hold_data;
        logic       hold_last;
        logic       hold_dest;
        stall = 1'b0;
        forever begin
            @(posedge clk);
            checks++;
            if (out_valid === 2'b11) begin
                $display("FAIL onehot_out_valid got=%b required=at most one bit", out_valid);
                failures++;
            end
            if (stall) begin
                checks++;
                if (in_data !== hold_data || in_last !== hold_last || in_dest !== hold_dest) begin
                    $display("FAIL producer_hold got=%h/%b/%b required=%h/%b/%b",
                             in_data, in_last, in_dest, hold_data, hold_last, hold_dest);
                    failures++;
                end
            end
            stall     = in_valid && !in_ready && !rst;
            hold_data = in_data;
            hold_last = in_last;
            hold_dest = in_dest;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic dst, input logic l);
        in_valid = v;
        in_data  = d;
        in_dest  = dst;
        in_last  = l;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 2'b11;
        out_ready = 2'b11;
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_in_ready got=%b required=0", in_ready); failures++;
        end
        tick;
        tick;
        checks++;
        if (out_valid !== 2'b00 || out_data !== 8'h00 || out_last !== 1'b0) begin
            $display("FAIL reset_slot got=%b/%h/%b required=00/00/0", out_valid, out_data, out_last); failures++;
        end
        checks++;
        if (sel !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_sel_busy got=%b/%b required=0/0", sel, busy); failures++;
        end
        checks++;
        if (pkt_cnt0 !== 8'd0 || pkt_cnt1 !== 8'd0 || drop_cnt !== 8'd0) begin
            $display("FAIL reset_counters got=%0d/%0d/%0d required=0/0/0", pkt_cnt0, pkt_cnt1, drop_cnt); failures++;
        end
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick;
    endtask

    task automatic test_single_beat;
        logic [1:0] exp_v;
        logic [7:0] exp_d;
        do_reset;
        en = 2'b11;
        out_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            exp_d = 8'(8'h11 * (i + 1));
            exp_v = i[0] ? 2'b10 : 2'b01;
            drive(1'b1, exp_d, i[0], 1'b1);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL single_in_ready beat=%0d got=%b required=1", i, in_ready); failures++;
            end
            if (i == 0) begin
                checks++;
                if (out_valid !== 2'b00) begin
                    $display("FAIL single_latency got=%b required=00", out_valid); failures++;
                end
            end
            tick;
            checks++;
            if (out_valid !== exp_v || out_data !== exp_d || out_last !== 1'b1) begin
                $display("FAIL single_out beat=%0d got=%b/%h/%b required=%b/%h/1",
                         i, out_valid, out_data, out_last, exp_v, exp_d); failures++;
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick;
        checks++;
        if (out_valid !== 2'b00 || pkt_cnt0 !== 8'd2 || pkt_cnt1 !== 8'd1 || busy !== 1'b0) begin
            $display("FAIL single_counts got=%b/%0d/%0d/%b required=00/2/1/0",
                     out_valid, pkt_cnt0, pkt_cnt1, busy); failures++;
        end
    endtask

    task automatic test_multi_beat;
        logic [7:0] exp_d;
        do_reset;
        en = 2'b11;
        out_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'(8'hA0 + i);
            drive(1'b1, exp_d, (i == 0) ? 1'b1 : 1'b0, (i == 3));
            if (i >= 2) en = 2'b01;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL multi_in_ready beat=%0d got=%b required=1", i, in_ready); failures++;
            end
            if (i > 0) begin
                checks++;
                if (sel !== 1'b1 || busy !== 1'b1) begin
                    $display("FAIL multi_sel_busy beat=%0d got=%b/%b required=1/1", i, sel, busy); failures++;
                end
            end
            tick;
            checks++;
            if (out_valid !== 2'b10 || out_data !== exp_d || out_last !== (i == 3)) begin
                $display("FAIL multi_out beat=%0d got=%b/%h/%b required=10/%h/%b",
                         i, out_valid, out_data, out_last, exp_d, (i == 3)); failures++;
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        en = 2'b11;
        checks++;
        if (busy !== 1'b0 || sel !== 1'b1) begin
            $display("FAIL multi_end_state got=%b/%b required=0/1", busy, sel); failures++;
        end
        tick;
        checks++;
        if (pkt_cnt1 !== 8'd1 || pkt_cnt0 !== 8'd0 || out_valid !== 2'b00) begin
            $display("FAIL multi_counts got=%0d/%0d/%b required=1/0/00", pkt_cnt1, pkt_cnt0, out_valid); failures++;
        end
    endtask

    task automatic test_drop;
        do_reset;
        en = 2'b10;
        out_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hD0 + i), (i == 0) ? 1'b0 : 1'b1, (i == 2));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL drop_in_ready beat=%0d got=%b required=1", i, in_ready); failures++;
            end
            tick;
            checks++;
            if (out_valid !== 2'b00) begin
                $display("FAIL drop_out_valid beat=%0d got=%b required=00", i, out_valid); failures++;
            end
            if (i < 2) begin
                checks++;
                if (busy !== 1'b1 || drop_cnt !== 8'd0) begin
                    $display("FAIL drop_mid beat=%0d got=%b/%0d required=1/0", i, busy, drop_cnt); failures++;
                end
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || drop_cnt !== 8'd1 || pkt_cnt0 !== 8'd0 || pkt_cnt1 !== 8'd0) begin
            $display("FAIL drop_end got=%b/%0d/%0d/%0d required=0/1/0/0", busy, drop_cnt, pkt_cnt0, pkt_cnt1); failures++;
        end
        tick;
    endtask

    task automatic test_concurrent_events;
        do_reset;
        en = 2'b11;
        out_ready = 2'b11;
        drive(1'b1, 8'hE1, 1'b0, 1'b1);
        tick;
        en = 2'b01;
        drive(1'b1, 8'hE2, 1'b1, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL concurrent_in_ready got=%b required=1", in_ready); failures++;
        end
        tick;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (pkt_cnt0 !== 8'd1 || drop_cnt !== 8'd1 || out_valid !== 2'b00) begin
            $display("FAIL concurrent_counts got=%0d/%0d/%b required=1/1/00", pkt_cnt0, drop_cnt, out_valid); failures++;
        end
        en = 2'b11;
        tick;
    endtask

    task automatic test_backpressure;
        do_reset;
        en = 2'b11;
        out_ready = 2'b11;
        drive(1'b1, 8'hB0, 1'b0, 1'b0);
        tick;
        en = 2'b00;
        drive(1'b1, 8'hB1, 1'b1, 1'b0);
        out_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 2'b01 || out_data !== 8'hB0) begin
                $display("FAIL bp_stall cycle=%0d got=%b/%b/%h required=0/01/b0",
                         k, in_ready, out_valid, out_data); failures++;
            end
            tick;
        end
        out_ready = 2'b11;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_resume_ready got=%b required=1", in_ready); failures++;
        end
        tick;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_valid !== 2'b01 || out_data !== 8'(8'hB0 + i)) begin
                $display("FAIL bp_stream beat=%0d got=%b/%h required=01/%h",
                         i, out_valid, out_data, 8'(8'hB0 + i)); failures++;
            end
            if (i < 3) begin
                drive(1'b1, 8'(8'hB1 + i), 1'b1, (i == 2));
                #1;
                checks++;
                if (in_ready !== 1'b1) begin
                    $display("FAIL bp_stream_ready beat=%0d got=%b required=1", i + 1, in_ready); failures++;
                end
                tick;
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        en = 2'b11;
        checks++;
        if (busy !== 1'b0 || pkt_cnt0 !== 8'd0) begin
            $display("FAIL bp_pre_count got=%b/%0d required=0/0", busy, pkt_cnt0); failures++;
        end
        tick;
        checks++;
        if (pkt_cnt0 !== 8'd1 || out_valid !== 2'b00) begin
            $display("FAIL bp_count got=%0d/%b required=1/00", pkt_cnt0, out_valid); failures++;
        end
    endtask

    task automatic test_reset_mid_packet;
        do_reset;
        en = 2'b11;
        out_ready = 2'b11;
        drive(1'b1, 8'hC0, 1'b1, 1'b0);
        tick;
        checks++;
        if (sel !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL rstmid_pre got=%b/%b required=1/1", sel, busy); failures++;
        end
        drive(1'b1, 8'hC1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL rstmid_in_ready got=%b required=0", in_ready); failures++;
        end
        tick;
        rst = 1'b0;
        checks++;
        if (out_valid !== 2'b00 || busy !== 1'b0 || sel !== 1'b0 || pkt_cnt1 !== 8'd0) begin
            $display("FAIL rstmid_after got=%b/%b/%b/%0d required=00/0/0/0", out_valid, busy, sel, pkt_cnt1); failures++;
        end
        drive(1'b1, 8'hC2, 1'b0, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL rstmid_new_ready got=%b required=1", in_ready); failures++;
        end
        tick;
        checks++;
        if (out_valid !== 2'b01 || out_data !== 8'hC2 || busy !== 1'b1) begin
            $display("FAIL rstmid_new_start got=%b/%h/%b required=01/c2/1", out_valid, out_data, busy); failures++;
        end
        drive(1'b1, 8'hC3, 1'b1, 1'b1);
        tick;
        checks++;
        if (out_valid !== 2'b01 || out_data !== 8'hC3 || busy !== 1'b0) begin
            $display("FAIL rstmid_new_last got=%b/%h/%b required=01/c3/0", out_valid, out_data, busy); failures++;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick;
        checks++;
        if (pkt_cnt0 !== 8'd1 || pkt_cnt1 !== 8'd0) begin
            $display("FAIL rstmid_counts got=%0d/%0d required=1/0", pkt_cnt0, pkt_cnt1); failures++;
        end
    endtask

    task automatic test_counter_wrap;
        logic [1:0] exp_w;
        do_reset;
        en = 2'b11;
        out_ready = 2'b11;
        drive(1'b1, 8'h70, 1'b0, 1'b1);
        tick;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 8'(8'h71 + i), 1'b0, 1'b1);
            else       drive(1'b0, 8'h00, 1'b0, 1'b0);
            tick;
            exp_w = 2'(i + 1);
            checks++;
            if (w_pkt_cnt0 !== exp_w || pkt_cnt0 !== 8'(i + 1)) begin
                $display("FAIL wrap_count pkt=%0d got=%0d/%0d required=%0d/%0d",
                         i + 1, w_pkt_cnt0, pkt_cnt0, exp_w, i + 1); failures++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 2'b11;
        out_ready = 2'b11;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        test_reset;
        test_single_beat;
        test_multi_beat;
        test_drop;
        test_concurrent_events;
        test_backpressure;
        test_reset_mid_packet;
        test_counter_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
